// File: rtl/sum_acc_pkg.sv
// Shared types and the accumulate-with-overflow helper for sum_frame_accumulator.
// SUM_ACC_SATURATE_EN selects clamping instead of wrap-around in acc_add().
package sum_acc_pkg;

    typedef enum logic [0:0] {
        ACCUM      = 1'b0,
        CLOSE_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        state_t state;
        logic   flush_pend;
    } dbg_t;

    // Widest accumulator the helper supports; ACC_W must stay below this.
    localparam int ADD_MAX_W = 64;

    typedef struct packed {
        logic                 ovf;
        logic [ADD_MAX_W-1:0] sum;
    } add_res_t;

    function automatic int sample_w(input int data_w);
        return data_w + 1;
    endfunction

    function automatic add_res_t acc_add(
        input logic [ADD_MAX_W-1:0] i_acc,
        input logic [ADD_MAX_W-1:0] i_sample,
        input int                   acc_w
    );
        localparam logic [ADD_MAX_W:0] ONE = (ADD_MAX_W + 1)'(1);
        logic [ADD_MAX_W:0] full;
        logic [ADD_MAX_W:0] lim;
        add_res_t           res;
        full    = {1'b0, i_acc} + {1'b0, i_sample};
        lim     = (ONE << acc_w) - ONE;
        res.ovf = (full > lim);
`ifdef SUM_ACC_SATURATE_EN
        res.sum = res.ovf ? lim[ADD_MAX_W-1:0] : full[ADD_MAX_W-1:0];
`else
        res.sum = full[ADD_MAX_W-1:0] & lim[ADD_MAX_W-1:0];
`endif
        return res;
    endfunction

endpackage

// File: rtl/sum_acc_out_slot.sv
// Single-entry valid/ready holding register for a finished frame result.
// A load always wins over a take, so a close during a handshake keeps o_valid high.
module sum_acc_out_slot
    import sum_acc_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [ACC_W-1:0] i_acc,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_ovf,
    input  logic             i_take,
    output logic             o_valid,
    output logic [ACC_W-1:0] o_acc,
    output logic [CNT_W-1:0] o_count,
    output logic             o_ovf
);

    logic             r_valid;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_acc   <= i_acc;
            r_count <= i_count;
            r_ovf   <= i_ovf;
        end else if (i_take) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_acc   = r_acc;
    assign o_count = r_count;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/sum_frame_accumulator.sv
// Accumulates {cout, sum} samples into fixed-length frames and emits one total per frame.
// Build option: define SUM_ACC_SATURATE_EN to clamp the total on overflow instead of wrapping.
module sum_frame_accumulator
    import sum_acc_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 24,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sum,
    input  logic              in_cout,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf,
    output dbg_t              dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid never waits on ready, and ready here may depend combinationally on out_ready.

    localparam int              SAMPLE_W = sample_w(DATA_W);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ovf;
    logic                r_flush_pend;

    logic [SAMPLE_W-1:0] w_sample_raw;
    logic [ACC_W-1:0]    w_sample;
    add_res_t            w_add;
    logic                w_add_ovf;
    logic                w_accept;
    logic                w_at_last;
    logic                w_slot_free;
    logic                w_full_close;
    logic                w_flush_close;
    logic                w_load;
    logic                w_set_pend;
    logic [ACC_W-1:0]    w_acc_next;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                w_ovf_next;

    assign w_sample_raw = {in_cout, in_sum};
    assign w_sample     = ACC_W'(w_sample_raw);
    assign w_add        = acc_add(ADD_MAX_W'(r_acc), ADD_MAX_W'(w_sample), ACC_W);
    // Any bit set above ACC_W would itself mean the total left the accumulator range.
    assign w_add_ovf    = w_add.ovf | (|w_add.sum[ADD_MAX_W-1:ACC_W]);

    assign w_at_last   = (r_cnt == LAST_IDX);
    assign w_slot_free = !out_valid || out_ready;
    assign in_ready    = (r_state == ACCUM) && !(w_at_last && out_valid && !out_ready);
    assign w_accept    = in_valid && in_ready;

    // Next-frame view including a sample accepted this cycle; this is also the close payload.
    assign w_acc_next    = w_accept ? w_add.sum[ACC_W-1:0] : r_acc;
    assign w_cnt_next    = r_cnt + CNT_W'(w_accept);
    assign w_ovf_next    = r_ovf | (w_accept & w_add_ovf);
    assign w_full_close  = w_accept && w_at_last;
    assign w_flush_close = flush && (w_cnt_next != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_set_pend   = 1'b0;
        case (r_state)
            ACCUM: begin
                if (w_full_close || w_flush_close) begin
                    if (w_slot_free) begin
                        w_load = 1'b1;
                    end else begin
                        w_set_pend   = 1'b1;
                        w_state_next = CLOSE_WAIT;
                    end
                end
            end
            CLOSE_WAIT: begin
                if (out_ready) begin
                    w_load       = 1'b1;
                    w_state_next = ACCUM;
                end
            end
            default: w_state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_ovf        <= 1'b0;
            r_flush_pend <= 1'b0;
        end else if (w_load) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_ovf        <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_next;
            r_ovf <= w_ovf_next;
            if (w_set_pend) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    sum_acc_out_slot #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) u_slot (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_acc   (w_acc_next),
        .i_count (w_cnt_next),
        .i_ovf   (w_ovf_next),
        .i_take  (out_ready),
        .o_valid (out_valid),
        .o_acc   (out_acc),
        .o_count (out_count),
        .o_ovf   (out_ovf)
    );

    assign dbg.state      = r_state;
    assign dbg.flush_pend = r_flush_pend;

endmodule

// File: tb/tb_sum_frame_accumulator.sv
// Self-checking bench for sum_frame_accumulator: directed tables, corner sequences,
// and randomized traffic checked against a frame-level reference model.
module tb_sum_frame_accumulator;
    import sum_acc_pkg::*;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_sum = '0;
    logic        in_cout = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_acc;
    logic [2:0]  out_count;
    logic        out_ovf;
    dbg_t        dbg;

    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [15:0] s_in_sum = '0;
    logic        s_in_cout = 1'b0;
    logic        s_flush = 1'b0;
    logic        s_out_valid;
    logic        s_out_ready = 1'b1;
    logic [16:0] s_out_acc;
    logic [1:0]  s_out_count;
    logic        s_out_ovf;
    dbg_t        s_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    int stall_cycles = 0;

    logic [27:0] got_q[$];
    logic [27:0] exp_q[$];

    // Reference model state (frame level)
    longint m_total = 0;
    int     m_n = 0;
    logic   m_slot = 1'b0;
    logic   m_pend = 1'b0;

    // Stability tracking
    logic        held = 1'b0;
    logic [27:0] held_val = '0;

    sum_frame_accumulator #(.DATA_W(16), .ACC_W(24), .FRAME_LEN(L)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_cout(in_cout), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .out_count(out_count), .out_ovf(out_ovf), .dbg(dbg)
    );

    sum_frame_accumulator #(.DATA_W(16), .ACC_W(17), .FRAME_LEN(2)) dut_small (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_sum(s_in_sum), .in_cout(s_in_cout), .flush(s_flush),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_acc(s_out_acc),
        .out_count(s_out_count), .out_ovf(s_out_ovf), .dbg(s_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [27:0] pk(input logic [23:0] a, input logic [2:0] c, input logic o);
        return {o, c, a};
    endfunction

    // Frame total from the plain arithmetic sum of its samples.
    function automatic logic [27:0] ref_frame(input longint total, input int n);
        longint lim;
        longint t;
        logic   o;
        lim = (longint'(1) << 24) - 1;
        o   = (total > lim);
`ifdef SUM_ACC_SATURATE_EN
        t = o ? lim : total;
`else
        t = total % (lim + 1);
`endif
        return {o, 3'(n), 24'(t)};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Monitor: collect handshaked results and check outputs hold while stalled.
    always @(negedge clk) begin
        if (rst && held) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_data", {out_ovf, out_count, out_acc}, held_val);
        end
        held     = rst && out_valid && !out_ready;
        held_val = {out_ovf, out_count, out_acc};
        if (rst && out_valid && out_ready) got_q.push_back({out_ovf, out_count, out_acc});
    end

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        got_q.delete();
    endtask

    task automatic send(input logic [15:0] s, input logic c);
        int waits;
        waits = 0;
        in_valid = 1'b1; in_sum = s; in_cout = c;
        @(negedge clk);
        while (!in_ready && waits < 40) begin
            waits++;
            stall_cycles++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: in_ready got 0 required 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic wait_got(input string name, input int n);
        int k;
        k = 0;
        while (got_q.size() < n && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, got_q.size(), n);
    endtask

    task automatic pop_expect(input string name, input logic [27:0] exp);
        if (got_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s: got no result required %0h", name, exp);
        end else begin
            check(name, got_q.pop_front(), exp);
        end
    endtask

    task automatic model_cycle();
        logic exp_rdy;
        logic into;
        exp_rdy = !m_pend && !(m_n == L - 1 && m_slot && !out_ready);
        check("rnd_in_ready", in_ready, exp_rdy);
        check("rnd_out_valid", out_valid, m_slot);
        if (in_valid && in_ready) begin
            m_total += longint'({in_cout, in_sum});
            m_n++;
        end
        into = 1'b0;
        if (m_pend) begin
            if (out_ready) begin
                m_pend = 1'b0;
                into = 1'b1;
            end
        end else if (m_n == L || (flush && m_n > 0)) begin
            exp_q.push_back(ref_frame(m_total, m_n));
            m_total = 0;
            m_n = 0;
            if (m_slot && !out_ready) m_pend = 1'b1;
            else into = 1'b1;
        end
        if (into) m_slot = 1'b1;
        else if (out_ready) m_slot = 1'b0;
    endtask

    typedef struct {
        int          n;
        logic [15:0] s;
        logic        c;
        logic        fl;
        logic [23:0] e_acc;
        logic [2:0]  e_cnt;
        logic        e_ovf;
    } vec_t;

    typedef struct {
        logic [16:0] a;
        logic [16:0] b;
        logic [16:0] e_wrap;
        logic [16:0] e_sat;
        logic        e_ovf;
    } svec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vec_t  vecs[6];
        svec_t svecs[4];

        vecs[0] = '{4, 16'h0001, 1'b0, 1'b0, 24'h000004, 3'd4, 1'b0};
        vecs[1] = '{4, 16'hFFFF, 1'b1, 1'b0, 24'h07FFFC, 3'd4, 1'b0};
        vecs[2] = '{4, 16'h0002, 1'b0, 1'b0, 24'h000008, 3'd4, 1'b0};
        vecs[3] = '{2, 16'h0005, 1'b0, 1'b1, 24'h00000A, 3'd2, 1'b0};
        vecs[4] = '{1, 16'hABCD, 1'b1, 1'b1, 24'h01ABCD, 3'd1, 1'b0};
        vecs[5] = '{3, 16'h8000, 1'b0, 1'b1, 24'h018000, 3'd3, 1'b0};

        svecs[0] = '{17'h1FFFF, 17'h1FFFF, 17'h1FFFE, 17'h1FFFF, 1'b1};
        svecs[1] = '{17'h10000, 17'h0FFFF, 17'h1FFFF, 17'h1FFFF, 1'b0};
        svecs[2] = '{17'h10000, 17'h10000, 17'h00000, 17'h1FFFF, 1'b1};
        svecs[3] = '{17'h00001, 17'h00002, 17'h00003, 17'h00003, 1'b0};

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_acc", out_acc, 24'h0);
        check("rst_out_count", out_count, 3'd0);
        check("rst_out_ovf", out_ovf, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_state", dbg.state == ACCUM, 1'b1);
        @(posedge clk); #1;

        // Table-driven single frames
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < vecs[i].n; j++) send(vecs[i].s, vecs[i].c);
            if (vecs[i].fl) pulse_flush();
            check("vec_latency", out_valid, 1'b1);
            wait_got("vec_count", 1);
            pop_expect("vec_result", pk(vecs[i].e_acc, vecs[i].e_cnt, vecs[i].e_ovf));
        end

        // Back-to-back frames with no in_ready drop
        stall_cycles = 0;
        for (int j = 0; j < 4; j++) send(16'hFFFF, 1'b1);
        for (int j = 0; j < 4; j++) send(16'h0002, 1'b0);
        check("b2b_no_stall", stall_cycles, 0);
        wait_got("b2b_count", 2);
        pop_expect("b2b_first", pk(24'h07FFFC, 3'd4, 1'b0));
        pop_expect("b2b_second", pk(24'h000008, 3'd4, 1'b0));

        // Output stalled: in_ready drops on the last sample of the second frame
        out_ready = 1'b0;
        for (int j = 0; j < 7; j++) send(16'h0001, 1'b0);
        in_valid = 1'b1; in_sum = 16'h0001; in_cout = 1'b0;
        @(negedge clk);
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_out_acc", out_acc, 24'h4);
        repeat (3) @(negedge clk);
        check("stall_in_ready_hold", in_ready, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_release_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("stall_reload_valid", out_valid, 1'b1);
        wait_got("stall_count", 2);
        pop_expect("stall_first", pk(24'h4, 3'd4, 1'b0));
        pop_expect("stall_second", pk(24'h4, 3'd4, 1'b0));

        // Flush of an empty frame produces nothing
        pulse_flush();
        repeat (3) @(posedge clk);
        #1;
        check("empty_flush_valid", out_valid, 1'b0);
        check("empty_flush_none", got_q.size(), 0);

        // Flush while the slot is busy waits in CLOSE_WAIT
        out_ready = 1'b0;
        for (int j = 0; j < 4; j++) send(16'h0001, 1'b0);
        send(16'h0003, 1'b0);
        send(16'h0003, 1'b0);
        pulse_flush();
        @(negedge clk);
        check("cw_state", dbg.state == CLOSE_WAIT, 1'b1);
        check("cw_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("cw_in_ready_out", in_ready, 1'b0);
        @(posedge clk); #1;
        check("cw_back_accum", dbg.state == ACCUM, 1'b1);
        check("cw_valid", out_valid, 1'b1);
        wait_got("cw_count", 2);
        pop_expect("cw_first", pk(24'h4, 3'd4, 1'b0));
        pop_expect("cw_flushed", pk(24'h6, 3'd2, 1'b0));

        // Reset mid-frame discards the partial frame
        for (int j = 0; j < 3; j++) send(16'h0007, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int j = 0; j < 4; j++) send(16'h0001, 1'b0);
        wait_got("midrst_count", 1);
        pop_expect("midrst_result", pk(24'h4, 3'd4, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        check("midrst_no_stale", got_q.size(), 0);

        // Narrow accumulator overflow behaviour
        for (int i = 0; i < 4; i++) begin
            s_in_valid = 1'b1;
            {s_in_cout, s_in_sum} = svecs[i].a;
            @(posedge clk); #1;
            check("small_in_ready", s_in_ready, 1'b1);
            {s_in_cout, s_in_sum} = svecs[i].b;
            @(posedge clk); #1;
            s_in_valid = 1'b0;
            check("small_valid", s_out_valid, 1'b1);
            check("small_count", s_out_count, 2'd2);
`ifdef SUM_ACC_SATURATE_EN
            check("small_acc", s_out_acc, svecs[i].e_sat);
`else
            check("small_acc", s_out_acc, svecs[i].e_wrap);
`endif
            check("small_ovf", s_out_ovf, svecs[i].e_ovf);
        end

        // Randomized traffic against the frame-level model
        do_reset();
        exp_q.delete();
        m_total = 0; m_n = 0; m_slot = 1'b0; m_pend = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_sum    = 16'($urandom);
            in_cout   = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            model_cycle();
            @(posedge clk); #1;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            model_cycle();
            @(posedge clk); #1;
        end
        check("rnd_frame_total", got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            check("rnd_frame", got_q.pop_front(), exp_q.pop_front());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sum_frame_accumulator.md
# sum_frame_accumulator

Downstream consumer of the 16-bit full-adder stage. Takes each registered sum word plus its carry-out as one 17-bit sample and accumulates samples over fixed-length frames. Emits one frame total per frame on a valid/ready output port for the checker/readout logic that follows. Sustains one sample per cycle and stalls upstream only when a completed frame cannot be handed off.

## Interface
Parameters:
- DATA_W, 16, width of incoming sum word; sample is {cout, sum}, DATA_W+1 bits.
- ACC_W, 24, accumulator and result width; must be ≥ DATA_W+1.
- FRAME_LEN, 16, samples per frame; must be ≥ 1.
- CNT_W, $clog2(FRAME_LEN+1), derived count width; do not override.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  sample present.
- in_ready  out  1  block accepts the sample this cycle.
- in_sum  in  DATA_W  sum word from the adder stage.
- in_cout  in  1  carry-out paired with in_sum.
- flush  in  1  single-cycle pulse; closes the current frame early.
- out_valid  out  1  frame result held.
- out_ready  in  1  consumer takes the result.
- out_acc  out  ACC_W  frame total.
- out_count  out  CNT_W  samples in the frame (FRAME_LEN, or fewer after a flush).
- out_ovf  out  1  accumulation overflowed during the frame.

## Operation
- Accept: in_valid && in_ready. Sample = {in_cout, in_sum}, zero-extended to ACC_W.
- Internal registers: acc, cnt, ovf, flush_pend. Output slot: out_valid, out_acc, out_count, out_ovf.
- FSM states:
  - ACCUM: normal running state.
  - CLOSE_WAIT: a flush is pending and the slot is busy.
- Frame close happens when an accepted sample makes cnt+1 == FRAME_LEN, or when a flush is taken with the effective count > 0.
- Effective count = cnt, plus 1 if a sample is accepted the same cycle.
- A sample accepted in the same cycle as a flush is included in the frame being closed.
- On close, if the slot is free or freed this cycle (!out_valid || out_ready):
  - load the slot with the total including any same-cycle sample;
  - clear acc, cnt and ovf.
- in_ready = !(cnt == FRAME_LEN-1 && out_valid && !out_ready) && state == ACCUM. This is combinational from out_ready.
- Flush with effective count == 0 is ignored; no output is produced.
- Flush while the slot is busy and out_ready is low:
  - set flush_pend and enter CLOSE_WAIT;
  - in_ready stays 0 in CLOSE_WAIT;
  - close on the first cycle out_ready is seen, then return to ACCUM.
- Overflow: ovf is set when acc+sample exceeds 2^ACC_W-1. The sum wraps modulo 2^ACC_W by default (see Configuration). ovf is per-frame, not sticky across frames.
- The slot clears out_valid on out_ready when no new close occurs that cycle.
- A close in the same cycle as a handshake reloads the slot, so out_valid stays 1.

## Timing
- Reset (rst=0 at an edge) sets:
  - out_valid=0, out_acc=0, out_count=0, out_ovf=0;
  - acc=0, cnt=0, flush_pend=0, state=ACCUM.
- in_ready=1 in the cycle after reset release.
- Reset mid-frame discards the partial frame and any unconsumed result.
- Latency: out_valid rises 1 cycle after the closing sample or flush is accepted.
- Throughput: 1 sample/cycle with out_ready held high, including back-to-back frames.
- FRAME_LEN=1: every sample is its own frame.
- Outputs are stable while out_valid && !out_ready.

## Configuration
- Macro: SUM_ACC_SATURATE_EN.
- Defined: on overflow, acc clamps to 2^ACC_W-1 and stays there for the rest of the frame. ovf=1.
- Undefined: wrap-around modulo 2^ACC_W. ovf=1.
- All other behaviour is identical in both builds.

## Structure
- Package sum_acc_pkg holds:
  - the state enum (ACCUM, CLOSE_WAIT);
  - a SAMPLE_W = DATA_W+1 helper;
  - a function computing the add result plus overflow (wrap vs saturate selected under the macro).
- One sub-module: sum_acc_out_slot, the valid/ready holding register for out_acc, out_count and out_ovf, with load and take logic.
- Top-level holds the FSM, acc/cnt and the in_ready logic.

## Test plan
All scenarios use FRAME_LEN=4, ACC_W=24 unless noted.
1. Reset, then 4 samples sum=0x0001 cout=0, out_ready=1 → out_valid one cycle after the 4th; out_acc=0x000004, out_count=4, out_ovf=0.
2. 4 samples sum=0xFFFF cout=1 back-to-back, followed immediately by 4 samples of 0x0002 → results 0x07FFFC then 0x000008 on consecutive frames, no in_ready drop.
3. out_ready=0, 8 samples of 1 → first result held stable; in_ready=0 at the 8th sample until out_ready=1; then second result out_acc=4.
4. 2 samples of 5, then flush → out_acc=10, out_count=2. Flush with cnt=0 → no out_valid. Flush with slot busy → CLOSE_WAIT; result emitted after out_ready.
5. ACC_W=17, FRAME_LEN=2, 2 samples of 0x1FFFF → wrap build: out_acc=0x1FFFE, out_ovf=1. SUM_ACC_SATURATE_EN build: out_acc=0x1FFFF, out_ovf=1.
6. 3 samples accepted, rst low one cycle, then 4 samples of 1 → out_acc=4, out_count=4; no stale result.
